// File: rtl/usb_buf_pkg.sv
// Shared constants and types for the USB data buffer: depth, occupancy width
// and the AHB transfer-size encoding.
package usb_buf_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int OCC_W     = 7;

  typedef enum logic [1:0] {
    DS_1B = 2'd0,
    DS_2B = 2'd1,
    DS_3B = 2'd2,
    DS_4B = 2'd3
  } data_size_t;

  // The AHB size field holds the byte count minus one.
  function automatic logic [2:0] bytes_of(input data_size_t ds);
    return 3'(ds) + 3'd1;
  endfunction

endpackage

// File: rtl/buf_ptr_ctrl.sv
// Pointer, occupancy and sticky-flag bookkeeping for the circular byte buffer.
// Decides how many bytes are pushed/popped each cycle; the byte storage lives in the top.
module buf_ptr_ctrl
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               data_size,
  input  logic                     store_tx_data,
  input  logic                     store_rx_packet_data,
  input  logic                     get_rx_data,
  input  logic                     get_tx_packet_data,
  output logic [$clog2(DEPTH):0]   wr_ptr,
  output logic [$clog2(DEPTH):0]   rd_ptr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     push_accept,
  output logic [2:0]               push_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int FW = PW + 1;

  logic [2:0]    push_req;
  logic [2:0]    pop_req;
  logic [2:0]    pop_count;
  logic [PW-1:0] push_add;
  logic [FW-1:0] free_space;
  logic          ovf_evt;
  logic          unf_evt;

  // Pops are resolved first so a full buffer can take a write in the same cycle as a read.
  always_comb begin
    push_req = 3'd0;
    if (store_tx_data)
      push_req = bytes_of(data_size_t'(data_size));
    else if (store_rx_packet_data)
      push_req = 3'd1;

    pop_req = 3'd0;
    if (get_rx_data)
      pop_req = bytes_of(data_size_t'(data_size));
    else if (get_tx_packet_data)
      pop_req = 3'd1;

    pop_count = pop_req;
    if (PW'(pop_req) > occupancy)
      pop_count = occupancy[2:0];

    free_space  = FW'(DEPTH) - FW'(occupancy) + FW'(pop_count);
    push_accept = (push_req != 3'd0) && (FW'(push_req) <= free_space);
    push_count  = push_req;
    push_add    = push_accept ? PW'(push_req) : '0;

    ovf_evt = (store_tx_data && store_rx_packet_data) ||
              ((push_req != 3'd0) && !push_accept);
    unf_evt = (get_rx_data && get_tx_packet_data) ||
              (PW'(pop_req) > occupancy);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + push_add;
      rd_ptr    <= rd_ptr + PW'(pop_count);
      occupancy <= occupancy + push_add - PW'(pop_count);
      overflow  <= overflow | ovf_evt;
      underflow <= underflow | unf_evt;
    end
  end

endmodule

// File: rtl/usb_data_buffer.sv
// Shared circular byte FIFO between the AHB slave and the USB RX/TX packet engines.
// Owns the byte memory plus the write scatter and read gather lanes.
module usb_data_buffer
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             data_size,
  input  logic                   store_tx_data,
  input  logic [31:0]            tx_data,
  input  logic                   get_rx_data,
  output logic [31:0]            rx_data,
  input  logic                   store_rx_packet_data,
  input  logic [7:0]             rx_packet_data,
  input  logic                   get_tx_packet_data,
  output logic [7:0]             tx_packet_data,
  output logic [$clog2(DEPTH):0] buffer_occupancy,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_accept;
  logic [2:0]    push_count;
  logic          wr_en;

  buf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .data_size            (data_size),
    .store_tx_data        (store_tx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .get_rx_data          (get_rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .wr_ptr               (wr_ptr),
    .rd_ptr               (rd_ptr),
    .occupancy            (buffer_occupancy),
    .push_accept          (push_accept),
    .push_count           (push_count),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  assign wr_en = push_accept && !flush && !rst;

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < push_count)
          mem[wr_ptr[AW-1:0] + AW'(i)] <= store_tx_data ? tx_data[8*i +: 8] : rx_packet_data;
      end
    end
  end

  always_comb begin
    rx_data = '0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) <= {1'b0, data_size}) && (PW'(i) < buffer_occupancy))
        rx_data[8*i +: 8] = mem[rd_ptr[AW-1:0] + AW'(i)];
    end
    tx_packet_data = (buffer_occupancy != '0) ? mem[rd_ptr[AW-1:0]] : 8'h00;
  end

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed self-checking bench for usb_data_buffer: ordering, size lanes, wrap,
// full/empty limits, sticky flags, flush and mid-stream reset.
module tb_usb_data_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic        store_tx_data = 1'b0;
  logic [31:0] tx_data = '0;
  logic        get_rx_data = 1'b0;
  logic [31:0] rx_data;
  logic        store_rx_packet_data = 1'b0;
  logic [7:0]  rx_packet_data = '0;
  logic        get_tx_packet_data = 1'b0;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  usb_data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .data_size            (data_size),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1ns after it, with all strobes dropped.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    store_tx_data = 1'b0;
    store_rx_packet_data = 1'b0;
    get_rx_data = 1'b0;
    get_tx_packet_data = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    data_size = 2'd3;
    #1;
    checks++;
    if (buffer_occupancy !== 7'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", buffer_occupancy); end
    checks++;
    if (rx_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rx_data got %h want 0", rx_data); end
    checks++;
    if (tx_packet_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_tx_byte got %h want 0", tx_packet_data); end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_size_reads();
    store_tx_data = 1'b1; data_size = 2'd3; tx_data = 32'h44332211;
    tick();
    checks++;
    if (buffer_occupancy !== 7'd4) begin errors++; $display("[TB] FAIL push4_occ got %0d want 4", buffer_occupancy); end
    get_rx_data = 1'b1; data_size = 2'd0;
    #1;
    checks++;
    if (rx_data !== 32'h00000011) begin errors++; $display("[TB] FAIL read1B got %h want 00000011", rx_data); end
    tick();
    checks++;
    if (buffer_occupancy !== 7'd3) begin errors++; $display("[TB] FAIL read1B_occ got %0d want 3", buffer_occupancy); end
    get_rx_data = 1'b1; data_size = 2'd1;
    #1;
    checks++;
    if (rx_data !== 32'h00003322) begin errors++; $display("[TB] FAIL read2B got %h want 00003322", rx_data); end
    tick();
    checks++;
    if (buffer_occupancy !== 7'd1) begin errors++; $display("[TB] FAIL read2B_occ got %0d want 1", buffer_occupancy); end
    do_flush();
  endtask

  task automatic test_fill_drain();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'(i);
      tick();
    end
    checks++;
    if (buffer_occupancy !== 7'd64) begin errors++; $display("[TB] FAIL fill_occ got %0d want 64", buffer_occupancy); end
    store_rx_packet_data = 1'b1; rx_packet_data = 8'hEE;
    tick();
    checks++;
    if (buffer_occupancy !== 7'd64 || overflow !== 1'b1)
      begin errors++; $display("[TB] FAIL store65 got occ=%0d ovf=%b want occ=64 ovf=1", buffer_occupancy, overflow); end
    for (int i = 0; i < 64; i++) begin
      get_tx_packet_data = 1'b1;
      #1;
      checks++;
      if (tx_packet_data !== 8'(i)) begin
        errors++; bad++;
        if (bad < 4) $display("[TB] FAIL drain_byte%0d got %h want %h", i, tx_packet_data, 8'(i));
      end
      tick();
    end
    checks++;
    if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'd0 || underflow !== 1'b0)
      begin errors++; $display("[TB] FAIL drained got occ=%0d tx=%h unf=%b want 0/00/0", buffer_occupancy, tx_packet_data, underflow); end
    do_flush();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 62; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'h10;
      tick();
      get_tx_packet_data = 1'b1;
      tick();
    end
    store_tx_data = 1'b1; data_size = 2'd3; tx_data = 32'hDDCCBBAA;
    tick();
    checks++;
    if (buffer_occupancy !== 7'd4 || tx_packet_data !== 8'hAA)
      begin errors++; $display("[TB] FAIL wrap_push got occ=%0d head=%h want 4/AA", buffer_occupancy, tx_packet_data); end
    get_rx_data = 1'b1; data_size = 2'd3;
    #1;
    checks++;
    if (rx_data !== 32'hDDCCBBAA) begin errors++; $display("[TB] FAIL wrap_read got %h want DDCCBBAA", rx_data); end
    tick();
    checks++;
    if (buffer_occupancy !== 7'd0 || underflow !== 1'b0)
      begin errors++; $display("[TB] FAIL wrap_pop got occ=%0d unf=%b want 0/0", buffer_occupancy, underflow); end
    do_flush();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 64; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'h80 + 8'(i);
      tick();
    end
    get_tx_packet_data = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'h5A;
    #1;
    checks++;
    if (tx_packet_data !== 8'h80) begin errors++; $display("[TB] FAIL full_head got %h want 80", tx_packet_data); end
    tick();
    checks++;
    if (buffer_occupancy !== 7'd64 || overflow !== 1'b0)
      begin errors++; $display("[TB] FAIL full_swap got occ=%0d ovf=%b want 64/0", buffer_occupancy, overflow); end
    for (int i = 0; i < 63; i++) begin
      get_tx_packet_data = 1'b1;
      tick();
    end
    checks++;
    if (buffer_occupancy !== 7'd1 || tx_packet_data !== 8'h5A)
      begin errors++; $display("[TB] FAIL full_tail got occ=%0d head=%h want 1/5A", buffer_occupancy, tx_packet_data); end
    do_flush();
    store_tx_data = 1'b1; data_size = 2'd1; tx_data = 32'h0000BEEF;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h77;
    tick();
    data_size = 2'd3;
    #1;
    checks++;
    if (buffer_occupancy !== 7'd2 || overflow !== 1'b1 || rx_data !== 32'h0000BEEF)
      begin errors++; $display("[TB] FAIL dual_store got occ=%0d ovf=%b rx=%h want 2/1/0000BEEF", buffer_occupancy, overflow, rx_data); end
    do_flush();
  endtask

  task automatic test_underflow_flush();
    store_tx_data = 1'b1; data_size = 2'd1; tx_data = 32'h00002211;
    tick();
    get_rx_data = 1'b1; data_size = 2'd3;
    #1;
    checks++;
    if (rx_data !== 32'h00002211) begin errors++; $display("[TB] FAIL short_read got %h want 00002211", rx_data); end
    tick();
    checks++;
    if (buffer_occupancy !== 7'd0 || underflow !== 1'b1)
      begin errors++; $display("[TB] FAIL short_pop got occ=%0d unf=%b want 0/1", buffer_occupancy, underflow); end
    do_flush();
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_unf got %b want 0", underflow); end
  endtask

  task automatic test_rst_midstream();
    for (int i = 0; i < 19; i++) begin
      store_rx_packet_data = 1'b1; rx_packet_data = 8'h30 + 8'(i);
      tick();
    end
    store_tx_data = 1'b1; data_size = 2'd0; tx_data = 32'h000000C3;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h99;
    tick();
    checks++;
    if (buffer_occupancy !== 7'd20 || overflow !== 1'b1)
      begin errors++; $display("[TB] FAIL pre_rst got occ=%0d ovf=%b want 20/1", buffer_occupancy, overflow); end
    rst = 1'b1;
    tick();
    data_size = 2'd3;
    #1;
    checks++;
    if (buffer_occupancy !== 7'd0 || rx_data !== 32'd0 || tx_packet_data !== 8'd0 || {overflow, underflow} !== 2'b00)
      begin errors++; $display("[TB] FAIL mid_rst got occ=%0d rx=%h tx=%h flags=%b want 0/0/0/00",
                               buffer_occupancy, rx_data, tx_packet_data, {overflow, underflow}); end
  endtask

  initial begin
    test_reset();
    test_size_reads();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_underflow_flush();
    test_rst_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
